md_unit: RTL

Iterative multiply/divide unit serving the execute stage of the five-stage pipeline CPU. It runs MIPS MULT, MULTU, DIV and DIVU. It takes one request through a start/busy/done handshake and returns a 64-bit result as {hi, lo} for the HI/LO registers. The execute stage holds its over signal low until done, which stalls everything upstream. The write-back cancel (syscall/eret) aborts an operation in flight.

---
 rtl/md_unit_if.sv | 15 +
 rtl/md_unit.sv | 136 +++++++++++++
 2 files changed

// File: rtl/md_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface md_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, src1, src2, cancel, input busy, done, hi, lo);
  modport slave  (input start, op, src1, src2, cancel, output busy, done, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit returning {hi, lo}; magnitude datapath with a sign-fix step.
// Optional MD_FAST_MUL_EN: multiplies bypass CALC via a single-cycle 32x32 multiplier.
module md_unit (
  input  logic     clk,
  input  logic     resetn,
  md_unit_if.slave md
);
  localparam int unsigned W  = 32;
  localparam int unsigned W2 = 64;
  localparam int unsigned CW = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state, state_nxt;
  logic          op_div, op_sgn, sa, sb;
  logic [W-1:0]  a_mag, b_mag;
  logic [W2-1:0] acc;
  logic [CW-1:0] cnt;
  logic          busy_q, done_q;
  logic [W-1:0]  hi_q, lo_q;

  logic          accept_c, borrow_c;
  logic [W-1:0]  src1_mag_c, src2_mag_c, quo_c, rem_c;
  logic [W:0]    mul_sum_c, rem_sh_c, diff_c;
  logic [W2-1:0] fixed_c;

  // Request acceptance and operand magnitudes
  always_comb begin
    accept_c   = (state == S_IDLE) && !busy_q && md.start && !md.cancel;
    src1_mag_c = (!md.op[0] && md.src1[W-1]) ? W'(-md.src1) : md.src1;
    src2_mag_c = (!md.op[0] && md.src2[W-1]) ? W'(-md.src2) : md.src2;
  end

  // Next-state logic; cancel aborts anything in flight
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept_c) begin
`ifdef MD_FAST_MUL_EN
          state_nxt = md.op[1] ? S_CALC : S_FIX;
`else
          state_nxt = S_CALC;
`endif
        end
      end
      S_CALC:  if (cnt == CW'(W - 1)) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
    if (md.cancel && (state != S_IDLE)) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // One shift-add / restoring step, plus the final sign correction
  always_comb begin
    mul_sum_c = {1'b0, acc[W2-1:W]} + {1'b0, a_mag & {W{b_mag[cnt]}}};
    rem_sh_c  = {acc[W2-1:W], a_mag[CW'(W - 1) - cnt]};
    diff_c    = rem_sh_c - {1'b0, b_mag};
    // A set top bit means the shifted remainder already exceeds any 32-bit divisor
    borrow_c  = !rem_sh_c[W] && diff_c[W];
    quo_c     = acc[W-1:0];
    rem_c     = acc[W2-1:W];
    fixed_c   = acc;
    if (op_div) begin
      // Divide-by-zero keeps the all-ones quotient; remainder negation restores raw src1
      fixed_c[W-1:0]  = (op_sgn && (sa ^ sb) && (b_mag != '0)) ? W'(-quo_c) : quo_c;
      fixed_c[W2-1:W] = (op_sgn && sa) ? W'(-rem_c) : rem_c;
    end else if (op_sgn && (sa ^ sb)) begin
      fixed_c = W2'(-acc);
    end
  end

  // Datapath and registered outputs; hi/lo publish one cycle after the sign fix
  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_div <= 1'b0;
      op_sgn <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      a_mag  <= '0;
      b_mag  <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= accept_c || ((state != S_IDLE) && !md.cancel);
      done_q <= (state == S_DONE) && !md.cancel;
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            op_div <= md.op[1];
            op_sgn <= !md.op[0];
            sa     <= md.src1[W-1];
            sb     <= md.src2[W-1];
            a_mag  <= src1_mag_c;
            b_mag  <= src2_mag_c;
            cnt    <= '0;
`ifdef MD_FAST_MUL_EN
            acc    <= md.op[1] ? '0 : W2'(src1_mag_c) * W2'(src2_mag_c);
`else
            acc    <= '0;
`endif
          end
        end
        S_CALC: begin
          cnt <= cnt + CW'(1);
          if (op_div) acc <= {(borrow_c ? rem_sh_c[W-1:0] : diff_c[W-1:0]), acc[W-2:0], !borrow_c};
          else        acc <= {mul_sum_c, acc[W-1:1]};
        end
        S_FIX: acc <= fixed_c;
        default: begin
          if (!md.cancel) begin
            hi_q <= acc[W2-1:W];
            lo_q <= acc[W-1:0];
          end
        end
      endcase
    end
  end

  assign md.busy = busy_q;
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;
endmodule
